// File: rtl/pe_stack_bus_upstream_tx_pkg.sv
// Shared definitions for the PE stack-bus upstream transmitter: cntl codes,
// header layout, framing states and the header builder.
package pe_stack_bus_upstream_tx_pkg;

    localparam logic [1:0] CNTL_MOP     = 2'b00;
    localparam logic [1:0] CNTL_SOP     = 2'b01;
    localparam logic [1:0] CNTL_EOP     = 2'b10;
    localparam logic [1:0] CNTL_SOP_EOP = 2'b11;

    localparam logic [3:0] HDR_TYPE     = 4'h1;
    localparam int         HDR_PE_LSB   = 24;
    localparam int         HDR_TAG_LSB  = 16;
    localparam int         HDR_TYPE_LSB = 12;

    // Wide enough for MAX_PKT_WORDS up to 4095.
    localparam int         CNT_W        = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CLOSE,
        ST_DRAIN
    } state_e;

    function automatic logic [31:0] make_header(input logic [7:0] pe_id, input logic [7:0] tag);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_PE_LSB +: 8]   = pe_id;
        hdr[HDR_TAG_LSB +: 8]  = tag;
        hdr[HDR_TYPE_LSB +: 4] = HDR_TYPE;
        return hdr;
    endfunction

endpackage

// File: rtl/pe_stack_bus_upstream_tx_fifo.sv
// Synchronous FIFO with show-ahead head; pointers wrap modulo DEPTH and the
// occupancy counter carries one extra bit so full and empty are distinct.
module pe_stack_bus_upstream_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pe_stack_bus_upstream_tx.sv
// Upstream transmitter: frames result words from the Ops block into stack-bus
// packets (header, data, EOP) behind a small input FIFO and a registered output.
module pe_stack_bus_upstream_tx
    import pe_stack_bus_upstream_tx_pkg::*;
#(
    parameter logic [7:0] PE_ID         = 8'd0,
    parameter int         DATA_W        = 32,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         MAX_PKT_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              stOp__sti__valid,
    input  logic [1:0]        stOp__sti__cntl,
    input  logic [7:0]        stOp__sti__tag,
    input  logic [DATA_W-1:0] stOp__sti__data,
    output logic              sti__stOp__ready,
    output logic              pe__stu__valid,
    output logic [1:0]        pe__stu__cntl,
    output logic [DATA_W-1:0] pe__stu__data,
    input  logic              stu__pe__ready,
    output logic              sti__err_len,
    output logic              sti__err_proto,
    input  logic              sti__err_clear
);

    localparam int               ENTRY_W = 2 + 8 + DATA_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_WORDS);

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [1:0]         head_cntl;
    logic [7:0]         head_tag;
    logic [DATA_W-1:0]  head_data;
    logic               head_sop, head_eop;
    logic [DATA_W-1:0]  hdr_word;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               vld_q, vld_d;
    logic [1:0]         cntl_q, cntl_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_len_q, err_len_d;
    logic               err_proto_q, err_proto_d;
    logic               set_len, set_proto;
    logic               adv;

    pe_stack_bus_upstream_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_poweron),
        .push_i  (fifo_push),
        .data_i  ({stOp__sti__cntl, stOp__sti__tag, stOp__sti__data}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Ready is forced low while reset is held so every output reads 0.
    assign sti__stOp__ready = reset_poweron && !fifo_full;
    assign fifo_push        = stOp__sti__valid && sti__stOp__ready;

    assign {head_cntl, head_tag, head_data} = fifo_head;
    assign head_sop = (head_cntl == CNTL_SOP) || (head_cntl == CNTL_SOP_EOP);
    assign head_eop = (head_cntl == CNTL_EOP) || (head_cntl == CNTL_SOP_EOP);
    assign hdr_word = DATA_W'(make_header(PE_ID, head_tag));
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // The output register may take a new word when empty or being accepted.
    assign adv = !vld_q || stu__pe__ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vld_d     = adv ? 1'b0 : vld_q;
        cntl_d    = cntl_q;
        data_d    = data_q;
        fifo_pop  = 1'b0;
        set_len   = 1'b0;
        set_proto = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_sop) begin
                        if (adv) begin
                            vld_d   = 1'b1;
                            cntl_d  = CNTL_SOP;
                            data_d  = hdr_word;
                            cnt_d   = '0;
                            state_d = ST_HDR;
                        end
                    end else begin
                        fifo_pop  = 1'b1;
                        set_proto = 1'b1;
                    end
                end
            end

            // In HDR the head is the packet's own SOP word, so only DATA can
            // see a second SOP.
            ST_HDR, ST_DATA: begin
                if (!fifo_empty && adv) begin
                    vld_d = 1'b1;
                    if (state_q == ST_DATA && head_cntl == CNTL_SOP) begin
                        cntl_d    = CNTL_EOP;
                        data_d    = '0;
                        set_proto = 1'b1;
                        state_d   = ST_CLOSE;
                    end else begin
                        fifo_pop = 1'b1;
                        data_d   = head_data;
                        cnt_d    = cnt_inc;
                        if (head_eop) begin
                            cntl_d  = CNTL_EOP;
                            state_d = ST_IDLE;
                        end else if (cnt_inc == MAX_CNT) begin
                            cntl_d  = CNTL_EOP;
                            set_len = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            cntl_d  = CNTL_MOP;
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            ST_CLOSE: begin
                if (!fifo_empty && adv) begin
                    vld_d   = 1'b1;
                    cntl_d  = CNTL_SOP;
                    data_d  = hdr_word;
                    cnt_d   = '0;
                    state_d = ST_HDR;
                end
            end

            ST_DRAIN: begin
                if (!fifo_empty) begin
                    if (head_sop) begin
                        if (adv) begin
                            vld_d     = 1'b1;
                            cntl_d    = CNTL_SOP;
                            data_d    = hdr_word;
                            cnt_d     = '0;
                            set_proto = 1'b1;
                            state_d   = ST_HDR;
                        end
                    end else begin
                        fifo_pop = 1'b1;
                        if (head_eop) state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // A set in the same cycle as a clear wins.
        err_len_d   = set_len   | (err_len_q   & !sti__err_clear);
        err_proto_d = set_proto | (err_proto_q & !sti__err_clear);
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vld_q       <= 1'b0;
            cntl_q      <= '0;
            data_q      <= '0;
            err_len_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            cntl_q      <= cntl_d;
            data_q      <= data_d;
            err_len_q   <= err_len_d;
            err_proto_q <= err_proto_d;
        end
    end

    assign pe__stu__valid = vld_q;
    assign pe__stu__cntl  = cntl_q;
    assign pe__stu__data  = data_q;
    assign sti__err_len   = err_len_q;
    assign sti__err_proto = err_proto_q;

endmodule

// File: tb/tb_pe_stack_bus_upstream_tx.sv
// Self-checking bench for pe_stack_bus_upstream_tx: directed vector table,
// hand-written timing sequences and random streams against a packet-level model.
module tb_pe_stack_bus_upstream_tx;

    localparam logic [7:0] PE   = 8'h07;
    localparam int         MAXW = 4;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        in_valid;
    logic [1:0]  in_cntl;
    logic [7:0]  in_tag;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_cntl;
    logic [31:0] out_data;
    logic        stu_ready;
    logic        err_len, err_proto, err_clear;

    always #5 clk = ~clk;

    pe_stack_bus_upstream_tx #(
        .PE_ID(PE), .DATA_W(32), .FIFO_DEPTH(4), .MAX_PKT_WORDS(MAXW)
    ) dut (
        .clk(clk), .reset_poweron(reset_poweron),
        .stOp__sti__valid(in_valid), .stOp__sti__cntl(in_cntl),
        .stOp__sti__tag(in_tag), .stOp__sti__data(in_data),
        .sti__stOp__ready(in_ready),
        .pe__stu__valid(out_valid), .pe__stu__cntl(out_cntl), .pe__stu__data(out_data),
        .stu__pe__ready(stu_ready),
        .sti__err_len(err_len), .sti__err_proto(err_proto), .sti__err_clear(err_clear)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: manual_ready
    logic        manual_ready = 1'b0;
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    logic [41:0] stim_q[$];
    logic        exp_len, exp_proto;

    typedef struct {
        string            name;
        int               n_in;
        logic [7:0][41:0] in_w;
        int               n_out;
        logic [7:0][33:0] out_w;
        logic             e_len;
        logic             e_proto;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] hdr(input logic [7:0] tag);
        return {PE, tag, 4'h1, 12'h000};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void vin(input int k, input logic [1:0] c, input logic [7:0] t, input logic [31:0] d);
        vecs[k].in_w[vecs[k].n_in] = {c, t, d};
        vecs[k].n_in++;
    endfunction

    function automatic void vout(input int k, input logic [1:0] c, input logic [31:0] d);
        vecs[k].out_w[vecs[k].n_out] = {c, d};
        vecs[k].n_out++;
    endfunction

    // Output side: set ready for the coming edge, then log the word that edge accepts.
    always @(negedge clk) begin
        case (ready_mode)
            0:       stu_ready = 1'b1;
            1:       stu_ready = ($urandom_range(0, 3) != 0);
            default: stu_ready = manual_ready;
        endcase
        #1;
        if (reset_poweron && out_valid && stu_ready) got_q.push_back({out_cntl, out_data});
    end

    task automatic push_word(input logic [41:0] w);
        int guard = 0;
        {in_cntl, in_tag, in_data} = w;
        in_valid = 1'b1;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: ready stayed 0 for %0d cycles, required 1", guard);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        int guard = 0;
        while (got_q.size() < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d words, required %0d", name, got_q.size(), n);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_flags();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clear_len", 64'(err_len), 64'(1'b0));
        check("clear_proto", 64'(err_proto), 64'(1'b0));
    endtask

    // Packet-level reference: parse the input stream into frames.
    function automatic void build_expected();
        int   i, n, cnt;
        logic [1:0] c;
        logic first, done, drained;
        i = 0;
        n = stim_q.size();
        exp_q.delete();
        exp_len = 1'b0;
        exp_proto = 1'b0;
        while (i < n) begin
            c = stim_q[i][41:40];
            if (c[0] == 1'b0) begin
                exp_proto = 1'b1;
                i++;
            end else begin
                exp_q.push_back({2'b01, hdr(stim_q[i][39:32])});
                cnt = 0; first = 1'b1; done = 1'b0;
                while (!done && i < n) begin
                    c = stim_q[i][41:40];
                    if (!first && c == 2'b01) begin
                        exp_q.push_back({2'b10, 32'h0});
                        exp_proto = 1'b1;
                        done = 1'b1;
                    end else begin
                        cnt++;
                        exp_q.push_back({(c[1] || cnt == MAXW) ? 2'b10 : 2'b00, stim_q[i][31:0]});
                        i++;
                        first = 1'b0;
                        if (c[1]) done = 1'b1;
                        else if (cnt == MAXW) begin
                            exp_len = 1'b1;
                            done = 1'b1;
                            drained = 1'b0;
                            while (i < n && !drained && stim_q[i][40] == 1'b0) begin
                                drained = stim_q[i][41];
                                i++;
                            end
                            if (!drained && i < n) exp_proto = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic gen_stream(input int npkt);
        bit after_trunc = 1'b0;
        int kind, len;
        logic [7:0] tg;
        logic [1:0] c;
        stim_q.delete();
        for (int p = 0; p < npkt; p++) begin
            kind = (p == npkt - 1 || after_trunc) ? 0 : $urandom_range(0, 9);
            tg = 8'($urandom);
            if (kind <= 5) begin
                len = $urandom_range(after_trunc ? 2 : 1, 6);
                for (int w = 0; w < len; w++) begin
                    c = (len == 1) ? 2'b11 : (w == 0) ? 2'b01 : (w == len - 1) ? 2'b10 : 2'b00;
                    stim_q.push_back({c, tg, 32'($urandom)});
                end
                after_trunc = 1'b0;
            end else if (kind <= 7) begin
                len = $urandom_range(1, 3);
                for (int w = 0; w < len; w++)
                    stim_q.push_back({(w == 0) ? 2'b01 : 2'b00, tg, 32'($urandom)});
                after_trunc = 1'b1;
            end else begin
                stim_q.push_back({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, tg, 32'($urandom)});
            end
        end
    endtask

    initial begin
        logic [34:0] held;
        reset_poweron = 1'b0;
        in_valid = 1'b0; in_cntl = '0; in_tag = '0; in_data = '0;
        err_clear = 1'b0;

        for (int k = 0; k < 7; k++) begin
            vecs[k].n_in = 0; vecs[k].n_out = 0; vecs[k].in_w = '0; vecs[k].out_w = '0;
        end
        vecs[0].name = "single";
        vin(0, 2'b01, 8'h5A, 1); vin(0, 2'b00, 8'h5A, 2); vin(0, 2'b10, 8'h5A, 3);
        vout(0, 2'b01, 32'h075A1000); vout(0, 2'b00, 1); vout(0, 2'b00, 2); vout(0, 2'b10, 3);
        vecs[0].e_len = 0; vecs[0].e_proto = 0;
        vecs[1].name = "sop_eop";
        vin(1, 2'b11, 8'h33, 32'hCAFE);
        vout(1, 2'b01, hdr(8'h33)); vout(1, 2'b10, 32'hCAFE);
        vecs[1].e_len = 0; vecs[1].e_proto = 0;
        vecs[2].name = "stray_mop";
        vin(2, 2'b00, 8'h00, 32'h99); vin(2, 2'b11, 8'h11, 32'h44);
        vout(2, 2'b01, hdr(8'h11)); vout(2, 2'b10, 32'h44);
        vecs[2].e_len = 0; vecs[2].e_proto = 1;
        vecs[3].name = "sop_in_data";
        vin(3, 2'b01, 8'hA1, 32'h10); vin(3, 2'b00, 8'hA1, 32'h11);
        vin(3, 2'b01, 8'hB2, 32'h20); vin(3, 2'b10, 8'hB2, 32'h21);
        vout(3, 2'b01, hdr(8'hA1)); vout(3, 2'b00, 32'h10); vout(3, 2'b00, 32'h11);
        vout(3, 2'b10, 32'h0); vout(3, 2'b01, hdr(8'hB2)); vout(3, 2'b00, 32'h20); vout(3, 2'b10, 32'h21);
        vecs[3].e_len = 0; vecs[3].e_proto = 1;
        vecs[4].name = "overlen";
        vin(4, 2'b01, 8'h0C, 1); for (int w = 2; w <= 5; w++) vin(4, 2'b00, 8'h0C, 32'(w));
        vin(4, 2'b10, 8'h0C, 6); vin(4, 2'b11, 8'h0D, 32'h77);
        vout(4, 2'b01, hdr(8'h0C)); vout(4, 2'b00, 1); vout(4, 2'b00, 2); vout(4, 2'b00, 3);
        vout(4, 2'b10, 4); vout(4, 2'b01, hdr(8'h0D)); vout(4, 2'b10, 32'h77);
        vecs[4].e_len = 1; vecs[4].e_proto = 0;
        vecs[5].name = "exact_max";
        vin(5, 2'b01, 8'hE0, 1); vin(5, 2'b00, 8'hE0, 2); vin(5, 2'b00, 8'hE0, 3); vin(5, 2'b10, 8'hE0, 4);
        vout(5, 2'b01, hdr(8'hE0)); vout(5, 2'b00, 1); vout(5, 2'b00, 2); vout(5, 2'b00, 3); vout(5, 2'b10, 4);
        vecs[5].e_len = 0; vecs[5].e_proto = 0;
        vecs[6].name = "drain_sop";
        vin(6, 2'b01, 8'h0E, 1); for (int w = 2; w <= 5; w++) vin(6, 2'b00, 8'h0E, 32'(w));
        vin(6, 2'b11, 8'h0F, 9);
        vout(6, 2'b01, hdr(8'h0E)); vout(6, 2'b00, 1); vout(6, 2'b00, 2); vout(6, 2'b00, 3);
        vout(6, 2'b10, 4); vout(6, 2'b01, hdr(8'h0F)); vout(6, 2'b10, 9);
        vecs[6].e_len = 1; vecs[6].e_proto = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        check("rst_ready", 64'(in_ready), 64'(1'b0));
        reset_poweron = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'(1'b1));
        check("post_rst_flags", 64'({err_len, err_proto}), 64'(2'b00));

        // Latency: header one edge after the push, first data the edge after
        in_cntl = 2'b01; in_tag = 8'h5A; in_data = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        check("lat_idle", 64'(out_valid), 64'(1'b0));
        in_cntl = 2'b10; in_data = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_hdr", 64'({out_valid, out_cntl, out_data}), 64'({1'b1, 2'b01, 32'h075A1000}));
        @(negedge clk);
        check("lat_d1", 64'({out_valid, out_cntl, out_data}), 64'({1'b1, 2'b00, 32'd1}));
        @(negedge clk);
        check("lat_d2", 64'({out_valid, out_cntl, out_data}), 64'({1'b1, 2'b10, 32'd2}));
        repeat (3) @(negedge clk);

        // Vector table
        for (int k = 0; k < 7; k++) begin
            clear_flags();
            got_q.delete();
            for (int j = 0; j < vecs[k].n_in; j++) push_word(vecs[k].in_w[j]);
            wait_out(vecs[k].n_out, vecs[k].name);
            check($sformatf("%s_count", vecs[k].name), 64'(got_q.size()), 64'(vecs[k].n_out));
            for (int j = 0; j < vecs[k].n_out && j < got_q.size(); j++)
                check($sformatf("%s_w%0d", vecs[k].name, j), 64'(got_q[j]), 64'(vecs[k].out_w[j]));
            check($sformatf("%s_len", vecs[k].name), 64'(err_len), 64'(vecs[k].e_len));
            check($sformatf("%s_proto", vecs[k].name), 64'(err_proto), 64'(vecs[k].e_proto));
        end

        // Set wins over a simultaneous clear
        err_clear = 1'b1;
        push_word({2'b00, 8'h00, 32'h1});
        @(negedge clk);
        check("set_wins", 64'(err_proto), 64'(1'b1));
        @(negedge clk);
        check("clear_after", 64'(err_proto), 64'(1'b0));
        err_clear = 1'b0;

        // Backpressure: output held, FIFO fills after four pushes
        ready_mode = 2; manual_ready = 1'b0;
        got_q.delete();
        for (int j = 0; j < 4; j++) begin
            push_word({(j == 0) ? 2'b01 : (j == 3) ? 2'b10 : 2'b00, 8'h5A, 32'(j + 100)});
            check($sformatf("bp_ready%0d", j), 64'(in_ready), 64'(j < 3));
        end
        for (int j = 0; j < 5; j++) begin
            held = {out_valid, out_cntl, out_data};
            check($sformatf("bp_hold%0d", j), 64'(held), 64'({1'b1, 2'b01, 32'h075A1000}));
            @(negedge clk);
        end
        manual_ready = 1'b1;
        wait_out(5, "bp");
        exp_q = '{{2'b01, 32'h075A1000}, {2'b00, 32'd100}, {2'b00, 32'd101}, {2'b00, 32'd102}, {2'b10, 32'd103}};
        check("bp_count", 64'(got_q.size()), 64'(5));
        for (int j = 0; j < 5 && j < got_q.size(); j++)
            check($sformatf("bp_w%0d", j), 64'(got_q[j]), 64'(exp_q[j]));

        // Random streams against the packet model
        ready_mode = 1;
        for (int r = 0; r < 3; r++) begin
            clear_flags();
            got_q.delete();
            gen_stream(40);
            build_expected();
            foreach (stim_q[j]) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                push_word(stim_q[j]);
            end
            wait_out(exp_q.size(), "rnd");
            check($sformatf("rnd%0d_count", r), 64'(got_q.size()), 64'(exp_q.size()));
            for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
                if (got_q[j] !== exp_q[j]) check($sformatf("rnd%0d_w%0d", r, j), 64'(got_q[j]), 64'(exp_q[j]));
            check($sformatf("rnd%0d_words", r), 64'(got_q.size() >= exp_q.size() ? 1 : 0), 64'(1));
            check($sformatf("rnd%0d_len", r), 64'(err_len), 64'(exp_len));
            check($sformatf("rnd%0d_proto", r), 64'(err_proto), 64'(exp_proto));
        end

        // Reset mid-packet: outputs drop at once, FIFO comes back empty
        ready_mode = 2; manual_ready = 1'b0;
        push_word({2'b00, 8'h00, 32'h1});
        push_word({2'b01, 8'h5A, 32'hAA});
        push_word({2'b00, 8'h5A, 32'hBB});
        repeat (2) @(negedge clk);
        check("mid_valid", 64'({out_valid, err_proto}), 64'(2'b11));
        #2 reset_poweron = 1'b0;
        #1;
        check("mid_rst_outs", 64'({out_valid, out_cntl, out_data, in_ready, err_len, err_proto}), 64'(0));
        @(negedge clk);
        reset_poweron = 1'b1;
        #1;
        check("mid_rel_ready", 64'(in_ready), 64'(1'b1));
        repeat (3) @(negedge clk);
        check("mid_rel_empty", 64'(out_valid), 64'(1'b0));
        ready_mode = 0;
        got_q.delete();
        push_word({2'b11, 8'h21, 32'h55});
        wait_out(2, "after_rst");
        check("after_rst_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() >= 2) begin
            check("after_rst_hdr", 64'(got_q[0]), 64'({2'b01, hdr(8'h21)}));
            check("after_rst_data", 64'(got_q[1]), 64'({2'b10, 32'h55}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
